// File: rtl/pc_ras.sv
// Program counter with jump-and-link and a circular return-address stack.
// Latency: one cycle from pc_op presentation to the new target on addr.
// Backpressure: stall=1 or fetch_ready=0 freezes PC and RAS; only a COP0 redirect still applies.
module pc_ras #(
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  INIT_ADDR = '0,
  parameter int                 RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              zero,
  input  logic              great,
  input  logic [15:0]       im1,
  input  logic [25:0]       im2,
  input  logic [3:0]        pc_op,
  input  logic [ADDR_W-1:0] j_reg,
  input  logic [ADDR_W-1:0] cop_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rt_addr,
  output logic              ras_empty,
  output logic              ras_ovf,
  output logic              ras_miss
);

  // PC operation encodings shared with decode/control.
  localparam logic [3:0] PC_OP_NOP   = 4'd0;
  localparam logic [3:0] PC_OP_BZ    = 4'd1;
  localparam logic [3:0] PC_OP_BNZ   = 4'd2;
  localparam logic [3:0] PC_OP_BG    = 4'd3;
  localparam logic [3:0] PC_OP_BNG   = 4'd4;
  localparam logic [3:0] PC_OP_BGZ   = 4'd5;
  localparam logic [3:0] PC_OP_BNGNZ = 4'd6;
  localparam logic [3:0] PC_OP_J     = 4'd7;
  localparam logic [3:0] PC_OP_JR    = 4'd8;
  localparam logic [3:0] PC_OP_COP0  = 4'd9;
  localparam logic [3:0] PC_OP_JAL   = 4'd10;
  localparam logic [3:0] PC_OP_RET   = 4'd11;

  localparam int PW = $clog2(RAS_DEPTH);

  localparam logic [PW-1:0] PTR_ONE  = 1;
  localparam logic [PW:0]   CNT_ONE  = 1;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]     top;
  logic [PW:0]       count;

  logic [ADDR_W-1:0] pc4;
  logic [ADDR_W-1:0] br;
  logic [ADDR_W-1:0] jmp;
  logic              adv;
  logic              tk;
  logic              is_branch;

  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W-1:0] rt_nxt;
  logic              push;
  logic              pop;
  logic              miss_nxt;

  assign adv       = !stall && fetch_ready;
  assign pc4       = addr + ADDR_W'(4);
  assign br        = addr + {{(ADDR_W-18){im1[15]}}, im1, 2'b00};
  assign jmp       = {addr[ADDR_W-1:28], im2, 2'b00};
  assign ras_empty = (count == '0);

  // Branch condition decode from the ALU flags.
  always_comb begin
    tk        = 1'b0;
    is_branch = 1'b1;
    case (pc_op)
      PC_OP_BZ:    tk = zero;
      PC_OP_BNZ:   tk = !zero;
      PC_OP_BG:    tk = great;
      PC_OP_BNG:   tk = !great;
      PC_OP_BGZ:   tk = zero || great;
      PC_OP_BNGNZ: tk = !zero && !great;
      default:     is_branch = 1'b0;
    endcase
  end

  // Next-PC selection in priority order; COP0 wins over a held pipeline.
  always_comb begin
    addr_nxt = addr;
    rt_nxt   = rt_addr;
    push     = 1'b0;
    pop      = 1'b0;
    miss_nxt = 1'b0;
    if (pc_op == PC_OP_COP0) begin
      addr_nxt = cop_addr;
      rt_nxt   = pc4;
    end else if (adv) begin
      rt_nxt = pc4;
      if (is_branch) begin
        addr_nxt = tk ? br : pc4;
      end else begin
        case (pc_op)
          PC_OP_J:   addr_nxt = jmp;
          PC_OP_JAL: begin
            addr_nxt = jmp;
            push     = 1'b1;
          end
          PC_OP_JR:  addr_nxt = j_reg;
          PC_OP_RET: begin
            if (!ras_empty) begin
              addr_nxt = ras_mem[top];
              pop      = 1'b1;
            end else begin
              addr_nxt = j_reg;
              miss_nxt = 1'b1;
            end
          end
          default:   addr_nxt = pc4;
        endcase
      end
    end
  end

  // PC, link register and RAS bookkeeping; a push when full drops the oldest entry.
  always_ff @(posedge clk) begin
    if (rest) begin
      addr     <= INIT_ADDR;
      rt_addr  <= '0;
      top      <= '0;
      count    <= '0;
      ras_ovf  <= 1'b0;
      ras_miss <= 1'b0;
    end else begin
      addr     <= addr_nxt;
      rt_addr  <= rt_nxt;
      ras_miss <= miss_nxt;
      if (push) begin
        top <= top + PTR_ONE;
        if (count == CNT_FULL) begin
          ras_ovf <= 1'b1;
        end else begin
          count <= count + CNT_ONE;
        end
      end else if (pop) begin
        top   <= top - PTR_ONE;
        count <= count - CNT_ONE;
      end
    end
  end

  // RAS storage: the slot above top receives the link address on a push.
  always_ff @(posedge clk) begin
    if (!rest && push) begin
      ras_mem[top + PTR_ONE] <= pc4;
    end
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised next-generation program counter for the MIPS core.
- Computes next-PC for sequential, branch, jump, register-jump and COP0 redirect. Adds a stall/ready hold, a jump-and-link path, and a circular return-address stack (RAS) for call/return.
- Sits between decode/control (pc_op, flags, immediates) and instruction fetch (addr).

Parameters:
- ADDR_W, 32, PC width; legal range 32..64.
- INIT_ADDR, 0, PC value after reset.
- RAS_DEPTH, 4, RAS entries; power of two, 2..16.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rest  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline hold; PC and RAS frozen except COP0 redirect.
- fetch_ready  in  1  fetch accepts addr this cycle; 0 acts as stall.
- zero  in  1  ALU zero flag.
- great  in  1  ALU greater flag.
- im1  in  16  branch offset, word units, signed.
- im2  in  26  jump index.
- pc_op  in  4  PC operation; shared PC_OP_* encodings plus new PC_OP_JAL and PC_OP_RET added to the common definitions.
- j_reg  in  ADDR_W  register jump target.
- cop_addr  in  ADDR_W  exception/eret target.
- addr  out  ADDR_W  current PC, registered.
- rt_addr  out  ADDR_W  link address (PC+4) of last advancing instruction, registered.
- ras_empty  out  1  RAS holds no entries.
- ras_ovf  out  1  sticky: a push overwrote a live entry.
- ras_miss  out  1  one-cycle pulse: RET executed with empty RAS.

Behaviour:
- Reset: addr=INIT_ADDR, rt_addr=0, RAS count=0, top pointer=0, ras_empty=1, ras_ovf=0, ras_miss=0. Reset overrides every other input. Reset mid-stall or mid-redirect discards that operation.
- Advance: adv = !stall && fetch_ready.
- Derived values:
  - pc4 = addr+4, wrapping modulo 2^ADDR_W.
  - br = addr + sign_extend(im1)<<2, wrapping.
  - jmp = {addr[ADDR_W-1:28], im2, 2'b00}.
- Branch taken (tk):
  - BZ: zero
  - BNZ: !zero
  - BG: great
  - BNG: !great
  - BGZ: zero|great
  - BNGNZ: !zero&&!great
- Next-PC priority, evaluated per clock:
  1. rest.
  2. pc_op==COP0: addr<=cop_addr, regardless of adv; RAS untouched.
  3. !adv: addr and rt_addr hold; no RAS change; ras_miss=0.
  4. Branch op with tk: addr<=br.
  5. J: addr<=jmp.
  6. JAL: addr<=jmp; push pc4.
  7. JR: addr<=j_reg.
  8. RET: if RAS non-empty, addr<=RAS[top] and pop; else addr<=j_reg and ras_miss=1 for one cycle.
  9. Otherwise, including branch not taken and unknown codes: addr<=pc4.
- rt_addr<=pc4 on every cycle where adv=1 or COP0 redirects.
- Latency: target visible on addr the cycle after the op is presented. No delay slot modelled.
- RAS is a circular buffer.
  - Push writes the slot above top and advances top; count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry and sets ras_ovf until reset.
  - Pop reads top, decrements top and count.
  - ras_empty = (count==0), registered with the state.
- Push and pop never occur in the same cycle, since one pc_op is active per cycle.
- Simulation-only $monitor/$display is allowed; nothing that affects synthesis.

Test Plan:
- Reset then 3 cycles with pc_op=NOP and adv=1 -> addr 0x0, 0x4, 0x8, 0xC; rt_addr lags and equals the prior addr+4.
- At addr=0x100, BZ with zero=1 and im1=0xFFFC -> addr=0xF0. Same with zero=0 -> addr=0x104. At addr=0xFFFFFFFC with NOP -> addr wraps to 0x0.
- stall=1 for 3 cycles with pc_op=J -> addr holds and the RAS is unchanged. Assert COP0 with cop_addr=0x80000180 during stall -> addr=0x80000180 next cycle.
- RAS_DEPTH=4: five JALs from 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_ovf=1. Then four RETs -> addr 0x54, 0x44, 0x34, 0x24 and ras_empty=1. A fifth RET with j_reg=0x999C -> addr=0x999C and ras_miss pulses for one cycle.
- JAL presented with fetch_ready=0 -> no push and ras_empty stays 1. rest asserted after 2 pushes -> addr=INIT_ADDR, ras_empty=1, ras_ovf=0.
- ADDR_W=64 with INIT_ADDR=0x1_0000_0000 and J im2=0x1 -> addr=0x1_0000_0004 (upper bits preserved).
